// File: rtl/cache_line_xfer.sv
// Cache line miss service engine: optional victim writeback, then line fill,
// one memory beat at a time, ending in a single-cycle done pulse.
module cache_line_xfer #(
  parameter int WAYS    = 2,
  parameter int TAG_W   = 9,
  parameter int SET_W   = 2,
  parameter int OFF_W   = 5,
  parameter int BEAT_LG = 3,
  localparam int ADDR_W = TAG_W + SET_W + OFF_W,
  localparam int BEATS  = 1 << (OFF_W - BEAT_LG),
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_dirty,
  input  logic [WAY_W-1:0]      victim_way,
  input  logic [WAYS*TAG_W-1:0] tags,
  output logic [ADDR_W-1:0]     pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  output logic [BEAT_W-1:0]     beat_idx,
  output logic                  fill_we,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t             state_reg;
  logic [SET_W-1:0]   set_reg;
  logic [TAG_W-1:0]   new_tag_reg;
  logic [TAG_W-1:0]   vtag_reg;
  logic [BEAT_W-1:0]  beat_reg;
  logic               last_beat;
  logic [OFF_W-1:0]   beat_off;
  logic [TAG_W-1:0]   line_tag;
  logic               unused_offset;

  // The requested byte offset is irrelevant: whole lines always move.
  assign unused_offset = ^req_addr[OFF_W-1:0];
  assign last_beat     = (beat_reg == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      set_reg     <= '0;
      new_tag_reg <= '0;
      vtag_reg    <= '0;
      beat_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            set_reg     <= req_addr[OFF_W +: SET_W];
            new_tag_reg <= req_addr[OFF_W+SET_W +: TAG_W];
            vtag_reg    <= tags[int'(victim_way)*TAG_W +: TAG_W];
            beat_reg    <= '0;
            state_reg   <= req_dirty ? WB : FILL;
          end
        end
        WB: begin
          if (pmem_resp) begin
            if (last_beat) begin
              beat_reg  <= '0;
              state_reg <= FILL;
            end else begin
              beat_reg  <= beat_reg + BEAT_W'(1);
            end
          end
        end
        FILL: begin
          if (pmem_resp) begin
            if (last_beat) begin
              beat_reg  <= '0;
              state_reg <= DONE;
            end else begin
              beat_reg  <= beat_reg + BEAT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outside a transfer the address rests on the base of the last latched line.
  assign line_tag     = (state_reg == WB) ? vtag_reg : new_tag_reg;
  assign beat_off     = OFF_W'(beat_reg) << BEAT_LG;
  assign pmem_address = {line_tag, set_reg,
                         ((state_reg == WB) || (state_reg == FILL)) ? beat_off : OFF_W'(0)};

  assign req_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign pmem_write = (state_reg == WB);
  assign pmem_read  = (state_reg == FILL);
  assign done       = (state_reg == DONE);
  assign fill_we    = (state_reg == FILL) && pmem_resp;
  assign beat_idx   = beat_reg;

endmodule

// File: tb/tb_cache_line_xfer.sv
// Bench for cache_line_xfer: vector table, random transfers against a line-level
// model, reset abort, and a single-beat configuration.
module tb_cache_line_xfer;

  localparam int TAG_W  = 9;
  localparam int SET_W  = 2;
  localparam int OFF_W  = 5;
  localparam int BEATS  = 4;
  localparam int BSTEP  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_dirty, pmem_resp;
  logic [15:0] req_addr, pmem_address;
  logic [0:0]  victim_way;
  logic [17:0] tags;
  logic        pmem_read, pmem_write, fill_we, done, busy;
  logic [1:0]  beat_idx;

  cache_line_xfer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_dirty(req_dirty), .victim_way(victim_way), .tags(tags),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .beat_idx(beat_idx), .fill_we(fill_we), .done(done), .busy(busy)
  );

  logic        req_valid_b, req_ready_b, req_dirty_b, pmem_resp_b;
  logic [14:0] req_addr_b, pmem_address_b;
  logic [1:0]  victim_way_b;
  logic [35:0] tags_b;
  logic        pmem_read_b, pmem_write_b, fill_we_b, done_b, busy_b;
  logic [0:0]  beat_idx_b;

  cache_line_xfer #(.WAYS(4), .TAG_W(9), .SET_W(2), .OFF_W(4), .BEAT_LG(4)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .req_dirty(req_dirty_b), .victim_way(victim_way_b), .tags(tags_b),
    .pmem_address(pmem_address_b), .pmem_read(pmem_read_b), .pmem_write(pmem_write_b),
    .pmem_resp(pmem_resp_b), .beat_idx(beat_idx_b), .fill_we(fill_we_b), .done(done_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level reference model: address arithmetic straight from the field layout.
  function automatic logic [15:0] line_base(input int tag, input int set);
    return 16'(tag * (1 << (SET_W + OFF_W)) + set * (1 << OFF_W));
  endfunction
  function automatic int tag_of(input logic [15:0] a);
    return int'(a) / (1 << (SET_W + OFF_W));
  endfunction
  function automatic int set_of(input logic [15:0] a);
    return (int'(a) / (1 << OFF_W)) % (1 << SET_W);
  endfunction

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    int          beat;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic        dirty;
    logic        vw;
    logic [17:0] tg;
    logic [15:0] wr_base;
    logic [15:0] rd_base;
    int          mode;
  } vec_t;

  // mode 0: respond every 2nd cycle, 1: random gaps, 2: 10-cycle stall on read beat 2
  function automatic int pick_wait(input int mode, input beat_t h);
    if (mode == 0) return 1;
    if (mode == 1) return int'($urandom_range(0, 3));
    return (!h.wr && h.beat == 2) ? 10 : 0;
  endfunction

  task automatic run_xfer(input vec_t v);
    int    waits;
    int    cyc;
    beat_t h;
    exp_q.delete();
    if (v.dirty)
      for (int i = 0; i < BEATS; i++) exp_q.push_back('{1'b1, v.wr_base + 16'(i*BSTEP), i});
    for (int i = 0; i < BEATS; i++) exp_q.push_back('{1'b0, v.rd_base + 16'(i*BSTEP), i});

    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    req_valid = 1'b1; req_addr = v.addr; req_dirty = v.dirty;
    victim_way = v.vw; tags = v.tg; pmem_resp = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    waits = pick_wait(v.mode, exp_q[0]);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      h = exp_q[0];
      check("wr_strobe", pmem_write, h.wr);
      check("rd_strobe", pmem_read, !h.wr);
      check("beat_addr", pmem_address, h.addr);
      check("beat_idx", beat_idx, h.beat);
      check("busy", busy, 1);
      check("no_early_done", done, 0);
      check("not_ready", req_ready, 0);
      pmem_resp  = (waits == 0);
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = 16'($urandom);
      req_dirty  = 1'($urandom);
      victim_way = 1'($urandom);
      tags       = 18'($urandom);
      #1 check("fill_we", fill_we, pmem_resp && !h.wr);
      if (pmem_resp) begin
        void'(exp_q.pop_front());
        if (exp_q.size() > 0) waits = pick_wait(v.mode, exp_q[0]);
      end else begin
        waits--;
      end
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) check("xfer_timeout", exp_q.size(), 0);
    check("done_pulse", done, 1);
    check("done_addr", pmem_address, v.rd_base);
    check("done_strobes", {pmem_read, pmem_write}, 0);
    check("done_beat", beat_idx, 0);
    pmem_resp = 1'($urandom);
    req_valid = 1'($urandom);
    @(negedge clk);
    check("done_once", done, 0);
    check("back_idle", req_ready, 1);
    check("idle_addr", pmem_address, v.rd_base);
    req_valid = 1'b0;
    pmem_resp = 1'($urandom);
    @(negedge clk);
    check("resp_in_idle", {req_ready, pmem_read, pmem_write, beat_idx}, 5'b10000);
    pmem_resp = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   cyc;
    logic [8:0] vtag;

    vecs[0] = '{16'h1234, 1'b0, 1'b0, {9'h155, 9'h0AB}, 16'h0000, 16'h1220, 0};
    vecs[1] = '{16'h1234, 1'b1, 1'b1, {9'h155, 9'h0AB}, 16'hAAA0, 16'h1220, 0};
    vecs[2] = '{16'h1234, 1'b0, 1'b0, {9'h155, 9'h0AB}, 16'h0000, 16'h1220, 2};
    vecs[3] = '{16'hFFFF, 1'b1, 1'b0, {9'h1FF, 9'h000}, 16'h0060, 16'hFFE0, 1};
    vecs[4] = '{16'h8041, 1'b1, 1'b0, {9'h000, 9'h0AB}, 16'h55C0, 16'h8040, 1};

    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_dirty = 1'b0; victim_way = '0; tags = '0; pmem_resp = 1'b0;
    req_valid_b = 1'b0; req_addr_b = '0; req_dirty_b = 1'b0; victim_way_b = '0; tags_b = '0; pmem_resp_b = 1'b0;
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_addr", pmem_address, 0);
    check("rst_strobes", {pmem_read, pmem_write, done}, 0);
    check("rst_beat", beat_idx, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      $display("vector %0d addr=0x%0h dirty=%0d mode=%0d", i, vecs[i].addr, vecs[i].dirty, vecs[i].mode);
      run_xfer(vecs[i]);
    end

    for (int i = 0; i < 20; i++) begin
      rv.addr  = 16'($urandom);
      rv.dirty = 1'($urandom);
      rv.vw    = 1'($urandom);
      rv.tg    = 18'($urandom);
      rv.mode  = 1;
      vtag     = rv.vw ? rv.tg[17:9] : rv.tg[8:0];
      rv.wr_base = line_base(int'(vtag), set_of(rv.addr));
      rv.rd_base = line_base(tag_of(rv.addr), set_of(rv.addr));
      $display("random %0d addr=0x%0h dirty=%0d way=%0d", i, rv.addr, rv.dirty, rv.vw);
      run_xfer(rv);
    end

    // Abort a dirty transfer on its second writeback beat.
    $display("reset during writeback");
    req_valid = 1'b1; req_addr = 16'h1234; req_dirty = 1'b1; victim_way = 1'b1; tags = {9'h155, 9'h0AB};
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!(pmem_write === 1'b1 && beat_idx === 2'd1) && cyc < 20) begin
      pmem_resp = 1'b1;
      @(negedge clk);
      cyc++;
    end
    pmem_resp = 1'b0;
    check("rst_reach_wb1", {pmem_write, beat_idx, pmem_address}, {1'b1, 2'd1, 16'hAAA8});
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", pmem_address, 0);
    check("mid_rst_strobes", {pmem_read, pmem_write, done}, 0);
    check("mid_rst_beat", beat_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {done, busy, req_ready}, 3'b001);
    end
    run_xfer(vecs[1]);

    // Single-beat configuration: one write, one read, done.
    $display("single beat config");
    req_valid_b = 1'b1; req_addr_b = 15'h5A3C; req_dirty_b = 1'b1; victim_way_b = 2'd3;
    tags_b = {9'h1A5, 9'h011, 9'h022, 9'h033};
    @(negedge clk);
    req_valid_b = 1'b0; tags_b = '0;
    check("b_write", {pmem_write_b, pmem_read_b, beat_idx_b}, 3'b100);
    check("b_wr_addr", pmem_address_b, 15'h6970);
    pmem_resp_b = 1'b1;
    @(negedge clk);
    check("b_read", {pmem_write_b, pmem_read_b, beat_idx_b}, 3'b010);
    check("b_rd_addr", pmem_address_b, 15'h5A30);
    #1 check("b_fill_we", fill_we_b, 1);
    @(negedge clk);
    pmem_resp_b = 1'b0;
    check("b_done", {done_b, busy_b, pmem_read_b, pmem_write_b}, 4'b1100);
    @(negedge clk);
    check("b_idle", {done_b, req_ready_b}, 2'b01);
    check("b_idle_addr", pmem_address_b, 15'h5A30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
